// File: rtl/cpu_types_pkg.sv
// Shared types for the MEM side of the 5-stage pipeline: word/register widths,
// the data-cache access FSM state and the EX/MEM latch record.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // One record so the whole EX/MEM latch is a single register.
  typedef struct packed {
    logic     valid;
    regbits_t rd;
    logic     regwr;
    logic     memrd;
    logic     memwr;
    logic     halt;
    word_t    alu_out;
    word_t    store_data;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-cache request bus between the MEM stage (master) and the dcache (slave).
// Handshake: dREN/dWEN stay high while an access is outstanding; the access
// retires on the first rising edge where dhit=1, and dload is valid in that cycle.
interface ex_mem_stage_if #(
  parameter int DW = 32
);
  logic          dREN;
  logic          dWEN;
  logic [DW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          dhit;
  logic [DW-1:0] dload;

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dhit, dload
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dhit, dload
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Data-cache access sequencer: tracks the outstanding request, generates the
// request strobes and the pipeline stall, and counts stalled cycles.
module mem_access_fsm
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             start_access,
  input  logic             dhit,
  input  logic             memrd,
  input  logic             memwr,
  output logic             dren,
  output logic             dwen,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output mem_state_t       state
);

  mem_state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The retiring edge is also a capture edge, so a following memory op
  // goes straight back into ACCESS.
  always_comb begin
    next_state = state;
    if (adv) next_state = start_access ? ACCESS : IDLE;
  end

  always_comb begin
    dren  = 1'b0;
    dwen  = 1'b0;
    stall = 1'b0;
    if (state == ACCESS) begin
      dren  = memrd;
      dwen  = memwr && !memrd;
      stall = !dhit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the dcache request handshake; bubbles on
// flush, holds upstream during outstanding accesses and freezes after halt.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int DW    = WORD_W,
  parameter int RW    = REG_W,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic             ex_memwr,
  input  logic [DW-1:0]    ex_alu_out,
  input  logic [DW-1:0]    ex_store_data,
  input  logic             ex_halt,
  input  logic             flush,
  ex_mem_stage_if.master   dbus,
  output logic             mem_valid,
  output logic [RW-1:0]    rd_mem,
  output logic             wr_mem,
  output logic             wm_mem,
  output logic [DW-1:0]    mem_alu_out,
  output logic [DW-1:0]    mem_load_data,
  output logic             mem_halt,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output mem_state_t       mem_state
);

  ex_mem_t latch_q;
  ex_mem_t capture;
  logic    adv;
  logic    start_access;

  assign adv = !stall && !latch_q.halt;

  // Bubbles clear the control fields but keep the data fields as they were.
  always_comb begin
    capture       = latch_q;
    capture.valid = 1'b0;
    capture.rd    = '0;
    capture.regwr = 1'b0;
    capture.memrd = 1'b0;
    capture.memwr = 1'b0;
    capture.halt  = 1'b0;
    if (ex_valid && !flush) begin
      capture.valid      = 1'b1;
      capture.rd         = ex_rd;
      capture.regwr      = ex_regwr && (ex_rd != '0);
      capture.memrd      = ex_memrd;
      capture.memwr      = ex_memwr && !ex_memrd;
      capture.halt       = ex_halt;
      capture.alu_out    = ex_alu_out;
      capture.store_data = ex_store_data;
    end
  end

  assign start_access = capture.memrd || capture.memwr;

  always_ff @(posedge CLK) begin
    if (RST)      latch_q <= '0;
    else if (adv) latch_q <= capture;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      mem_load_data <= '0;
    else if (mem_state == ACCESS && dbus.dhit && latch_q.memrd)
      mem_load_data <= dbus.dload;
  end

  mem_access_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk          (CLK),
    .rst          (RST),
    .adv          (adv),
    .start_access (start_access),
    .dhit         (dbus.dhit),
    .memrd        (latch_q.memrd),
    .memwr        (latch_q.memwr),
    .dren         (dbus.dREN),
    .dwen         (dbus.dWEN),
    .stall        (stall),
    .stall_cnt    (stall_cnt),
    .state        (mem_state)
  );

  assign dbus.daddr  = latch_q.alu_out;
  assign dbus.dstore = latch_q.store_data;

  assign mem_valid   = latch_q.valid;
  assign rd_mem      = latch_q.rd;
  assign wr_mem      = latch_q.regwr;
  assign wm_mem      = latch_q.memwr;
  assign mem_alu_out = latch_q.alu_out;
  assign mem_halt    = latch_q.halt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the EX/MEM stage.
module tb_ex_mem_stage;
  import cpu_types_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwr;
  logic        ex_memrd;
  logic        ex_memwr;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic        ex_halt;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  rd_mem;
  logic        wr_mem;
  logic        wm_mem;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_load_data;
  logic        mem_halt;
  logic        stall;
  logic [31:0] stall_cnt;
  mem_state_t  mem_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  ex_mem_stage_if #(.DW(32)) dbus_if ();

  ex_mem_stage dut (
    .CLK           (clk),
    .RST           (rst),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_regwr      (ex_regwr),
    .ex_memrd      (ex_memrd),
    .ex_memwr      (ex_memwr),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_halt       (ex_halt),
    .flush         (flush),
    .dbus          (dbus_if.master),
    .mem_valid     (mem_valid),
    .rd_mem        (rd_mem),
    .wr_mem        (wr_mem),
    .wm_mem        (wm_mem),
    .mem_alu_out   (mem_alu_out),
    .mem_load_data (mem_load_data),
    .mem_halt      (mem_halt),
    .stall         (stall),
    .stall_cnt     (stall_cnt),
    .mem_state     (mem_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = 0; ex_regwr = 0; ex_memrd = 0; ex_memwr = 0;
    ex_alu_out = 0; ex_store_data = 0; ex_halt = 0; flush = 0;
    dbus_if.dhit = 0; dbus_if.dload = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ex_valid = 1; ex_memrd = 1; ex_rd = 7; ex_regwr = 1; ex_alu_out = 32'h44;
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    total++; if ({mem_valid, wr_mem, wm_mem, mem_halt} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b need=0000", {mem_valid, wr_mem, wm_mem, mem_halt}); end
    total++; if ({dbus_if.dREN, dbus_if.dWEN, stall} !== 3'b0) begin bad++; $display("FAIL reset_req got=%b need=000", {dbus_if.dREN, dbus_if.dWEN, stall}); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d need=0", stall_cnt); end
    total++; if ({rd_mem, mem_alu_out, mem_load_data} !== 69'd0) begin bad++; $display("FAIL reset_data got=%h need=0", {rd_mem, mem_alu_out, mem_load_data}); end
    total++; if (mem_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d need=IDLE", mem_state); end
    tick();
    rst = 0;
    idle_inputs();
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    ex_valid = 1; ex_rd = 5; ex_regwr = 1; ex_alu_out = 32'h1234;
    tick();
    ex_rd = 0;
    @(negedge clk);
    total++; if ({mem_valid, rd_mem, wr_mem} !== {1'b1, 5'd5, 1'b1}) begin bad++; $display("FAIL alu_ctrl got=%b need=1001011", {mem_valid, rd_mem, wr_mem}); end
    total++; if (mem_alu_out !== 32'h1234) begin bad++; $display("FAIL alu_out got=%h need=00001234", mem_alu_out); end
    total++; if ({stall, dbus_if.dREN} !== 2'b00) begin bad++; $display("FAIL alu_nostall got=%b need=00", {stall, dbus_if.dREN}); end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if ({mem_valid, wr_mem} !== 2'b10) begin bad++; $display("FAIL alu_rd0 got=%b need=10", {mem_valid, wr_mem}); end
    tick();
  endtask

  task automatic test_load_miss();
    ex_valid = 1; ex_memrd = 1; ex_alu_out = 32'h100; ex_rd = 3; ex_regwr = 1;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin dbus_if.dhit = 1; dbus_if.dload = 32'hDEADBEEF; end
      @(negedge clk);
      total++; if ({dbus_if.dREN, dbus_if.dWEN, dbus_if.daddr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL load_req c=%0d got=%b %h need=10 00000100", c, {dbus_if.dREN, dbus_if.dWEN}, dbus_if.daddr); end
      total++; if (stall !== (c < 2)) begin bad++; $display("FAIL load_stall c=%0d got=%b need=%b", c, stall, c < 2); end
      if (c < 2) exp_cnt++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (mem_load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h need=deadbeef", mem_load_data); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL load_cnt got=%0d need=%0d", stall_cnt, exp_cnt); end
    total++; if ({mem_state, dbus_if.dREN} !== {IDLE, 1'b0}) begin bad++; $display("FAIL load_idle got=%b need=00", {mem_state, dbus_if.dREN}); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_memwr = 1; ex_alu_out = 32'h200; ex_store_data = 32'hA5A5A5A5;
    tick();
    ex_memwr = 0; ex_memrd = 1; ex_alu_out = 32'h204; ex_rd = 7; ex_regwr = 1;
    dbus_if.dhit = 1; dbus_if.dload = 32'h11112222;
    @(negedge clk);
    total++; if ({dbus_if.dWEN, dbus_if.dREN, stall} !== 3'b100) begin bad++; $display("FAIL b2b_store_req got=%b need=100", {dbus_if.dWEN, dbus_if.dREN, stall}); end
    total++; if ({dbus_if.daddr, dbus_if.dstore} !== {32'h200, 32'hA5A5A5A5}) begin bad++; $display("FAIL b2b_store_bus got=%h need=00000200a5a5a5a5", {dbus_if.daddr, dbus_if.dstore}); end
    tick();
    idle_inputs();
    dbus_if.dhit = 1; dbus_if.dload = 32'h33334444;
    @(negedge clk);
    total++; if ({mem_state, dbus_if.dREN, dbus_if.dWEN, stall} !== {ACCESS, 3'b100}) begin bad++; $display("FAIL b2b_load_req got=%b need=1100", {mem_state, dbus_if.dREN, dbus_if.dWEN, stall}); end
    total++; if (dbus_if.daddr !== 32'h204) begin bad++; $display("FAIL b2b_load_addr got=%h need=00000204", dbus_if.daddr); end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if (mem_load_data !== 32'h33334444) begin bad++; $display("FAIL b2b_load_data got=%h need=33334444", mem_load_data); end
    total++; if ({mem_state, stall_cnt} !== {IDLE, exp_cnt}) begin bad++; $display("FAIL b2b_end got=%0d/%0d need=IDLE/%0d", mem_state, stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    ex_valid = 1; ex_memrd = 1; ex_alu_out = 32'h300; ex_rd = 9; ex_regwr = 1;
    tick();
    flush = 1; ex_rd = 10; ex_alu_out = 32'h304;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin dbus_if.dhit = 1; dbus_if.dload = 32'hCAFEF00D; end
      @(negedge clk);
      total++; if (stall !== (c < 2)) begin bad++; $display("FAIL flush_stall c=%0d got=%b need=%b", c, stall, c < 2); end
      if (c < 2) exp_cnt++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total++; if ({mem_valid, wr_mem, rd_mem} !== 7'd0) begin bad++; $display("FAIL flush_bubble got=%b need=0000000", {mem_valid, wr_mem, rd_mem}); end
    total++; if ({mem_state, dbus_if.dREN, dbus_if.dWEN} !== {IDLE, 2'b00}) begin bad++; $display("FAIL flush_noreq got=%b need=000", {mem_state, dbus_if.dREN, dbus_if.dWEN}); end
    total++; if ({mem_load_data, stall_cnt} !== {32'hCAFEF00D, exp_cnt}) begin bad++; $display("FAIL flush_data got=%h/%0d need=cafef00d/%0d", mem_load_data, stall_cnt, exp_cnt); end
  endtask

  task automatic test_halt_reset();
    ex_valid = 1; ex_halt = 1; ex_alu_out = 32'h99;
    tick();
    ex_halt = 0; ex_rd = 12; ex_regwr = 1; ex_alu_out = 32'h55; ex_memrd = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if ({mem_halt, mem_valid, rd_mem, mem_alu_out} !== {2'b11, 5'd0, 32'h99}) begin bad++; $display("FAIL halt_frozen c=%0d got=%b %h need=11 0 00000099", c, {mem_halt, mem_valid, rd_mem}, mem_alu_out); end
      total++; if ({mem_state, dbus_if.dREN} !== {IDLE, 1'b0}) begin bad++; $display("FAIL halt_noreq c=%0d got=%b need=00", c, {mem_state, dbus_if.dREN}); end
      tick();
    end
    idle_inputs();
    do_reset();
    ex_valid = 1; ex_memrd = 1; ex_alu_out = 32'h400; ex_rd = 4; ex_regwr = 1;
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if ({mem_state, dbus_if.dREN, mem_halt} !== {ACCESS, 2'b10}) begin bad++; $display("FAIL rst_pre got=%b need=110", {mem_state, dbus_if.dREN, mem_halt}); end
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total++; if ({mem_state, dbus_if.dREN, stall, mem_halt, mem_valid} !== {IDLE, 4'b0000}) begin bad++; $display("FAIL rst_mid got=%b need=00000", {mem_state, dbus_if.dREN, stall, mem_halt, mem_valid}); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d need=0", stall_cnt); end
    exp_cnt = 0;
  endtask

  // Scoreboard: each captured memory op is queued with its expected retire
  // result; the model tracks what the MEM stage should hold cycle by cycle.
  task automatic test_random();
    logic [31:0] exp_q[$];
    logic        m_valid, m_wr, m_wm, m_ld, m_pend;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_sd, m_data;
    logic        e_stall;
    int          op;
    idle_inputs();
    do_reset();
    m_valid = 0; m_wr = 0; m_wm = 0; m_ld = 0; m_pend = 0; m_rd = 0;
    m_alu = 0; m_sd = 0; m_data = 0;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 2);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_rd         = 5'($urandom_range(0, 31));
      ex_regwr      = $urandom_range(0, 1) != 0;
      ex_memrd      = (op == 1);
      ex_memwr      = (op == 2);
      ex_alu_out    = $urandom;
      ex_store_data = $urandom;
      flush         = ($urandom_range(0, 5) == 0);
      dbus_if.dhit  = ($urandom_range(0, 2) == 0);
      dbus_if.dload = $urandom;
      @(negedge clk);
      e_stall = m_pend && !dbus_if.dhit;
      total++; if ({stall, dbus_if.dREN, dbus_if.dWEN} !== {e_stall, m_pend && m_ld, m_pend && m_wm}) begin bad++; $display("FAIL rnd_req n=%0d got=%b need=%b", n, {stall, dbus_if.dREN, dbus_if.dWEN}, {e_stall, m_pend && m_ld, m_pend && m_wm}); end
      total++; if ({mem_valid, rd_mem, wr_mem, wm_mem, mem_alu_out, mem_halt} !== {m_valid, m_rd, m_wr, m_wm, m_alu, 1'b0}) begin bad++; $display("FAIL rnd_latch n=%0d got=%b %h need=%b %h", n, {mem_valid, rd_mem, wr_mem, wm_mem}, mem_alu_out, {m_valid, m_rd, m_wr, m_wm}, m_alu); end
      total++; if ({mem_load_data, stall_cnt} !== {m_data, exp_cnt}) begin bad++; $display("FAIL rnd_data n=%0d got=%h/%0d need=%h/%0d", n, mem_load_data, stall_cnt, m_data, exp_cnt); end
      if (m_pend) begin
        total++; if ({dbus_if.daddr, m_wm ? dbus_if.dstore : 32'd0} !== {m_alu, m_wm ? m_sd : 32'd0}) begin bad++; $display("FAIL rnd_bus n=%0d got=%h need=%h", n, {dbus_if.daddr, dbus_if.dstore}, {m_alu, m_sd}); end
      end
      if (m_pend && dbus_if.dhit && m_ld) exp_q.push_back(dbus_if.dload);
      if (e_stall) exp_cnt++;
      if (!e_stall) begin
        if (exp_q.size() != 0) m_data = exp_q.pop_front();
        if (flush || !ex_valid) begin
          m_valid = 0; m_rd = 0; m_wr = 0; m_wm = 0; m_ld = 0; m_pend = 0;
        end else begin
          m_valid = 1; m_rd = ex_rd; m_wr = ex_regwr && (ex_rd != 0);
          m_ld = ex_memrd; m_wm = ex_memwr; m_pend = ex_memrd || ex_memwr;
          m_alu = ex_alu_out; m_sd = ex_store_data;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    exp_cnt = 0;
    test_reset();
    test_alu();
    test_load_miss();
    test_back_to_back();
    test_flush();
    test_halt_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the 5-stage MIPS pipeline, plus the data-cache request handshake for the MEM stage.
- Captures EX results each advance cycle. Drives the destination/write-enable fields that the operand-forwarding logic compares against.
- Issues dREN/dWEN to the dcache and holds upstream stages until the access completes.
- Inserts bubbles on flush and freezes permanently on halt.

Parameters:
- DW, 32, datapath/address width
- RW, 5, register index width
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  RW  destination register
- ex_regwr  in  1  instruction writes the register file
- ex_memrd  in  1  load
- ex_memwr  in  1  store
- ex_alu_out  in  DW  ALU result / effective address
- ex_store_data  in  DW  forwarded rt value for stores
- ex_halt  in  1  halt instruction
- flush  in  1  replace next captured instruction with a bubble
- dhit  in  1  dcache access complete this cycle
- dload  in  DW  dcache read data, valid when dhit=1
- dREN  out  1  dcache read request
- dWEN  out  1  dcache write request
- daddr  out  DW  dcache address
- dstore  out  DW  dcache write data
- mem_valid  out  1  MEM holds a real instruction
- rd_mem  out  RW  latched destination
- wr_mem  out  1  latched register-write enable
- wm_mem  out  1  latched memory-write flag
- mem_alu_out  out  DW  latched ALU result
- mem_load_data  out  DW  captured load data
- mem_halt  out  1  sticky halt reached MEM
- stall  out  1  freeze PC/IF/ID/EX latches this cycle
- stall_cnt  out  CNT_W  total cycles with stall=1

Behaviour:
- Reset: all registered outputs are 0, FSM is IDLE, stall_cnt is 0. dREN/dWEN/stall are 0 the cycle after RST is sampled high. RST asserted mid-access abandons the access with no completion.
- FSM has two states:
  - IDLE: no outstanding access.
  - ACCESS: request asserted, waiting for dhit.
- Advance condition: adv = !stall && !mem_halt. On a CLK edge with adv=1 the latch captures:
  - If flush=1 or ex_valid=0: a bubble (mem_valid, wr_mem, wm_mem, rd_mem, halt all 0; data fields don't-care but held).
  - Otherwise the EX fields. wr_mem = ex_regwr && (ex_rd!=0). mem_halt |= ex_halt.
  - If the captured instruction is a valid load or store, next state is ACCESS; otherwise IDLE.
- Without adv, all latch fields hold. flush is sampled only on advance edges; upstream holds flush while stall=1.
- In ACCESS:
  - dREN = latched memrd, dWEN = wm_mem.
  - daddr = mem_alu_out, dstore = latched store data.
  - Never both dREN and dWEN.
  - In IDLE, dREN=dWEN=0.
- stall = (state==ACCESS) && !dhit, combinational.
  - The dhit cycle is an advance cycle: the next instruction is captured on the same edge the access retires.
  - Minimum memory latency is therefore one cycle (dhit in the first ACCESS cycle means zero stall cycles).
- On a dhit edge, if the access is a load, mem_load_data <= dload. A back-to-back memory instruction captured on that edge re-enters ACCESS directly without passing through IDLE.
- After a load retires, mem_load_data holds until the next load hit.
- Halt:
  - Once mem_halt=1, adv is 0 forever and no further captures occur until RST.
  - A halt captured with a memory access pending is not possible, because halt is not a memory op.
- stall_cnt increments by 1 on every edge where stall=1 and wraps modulo 2^CNT_W.
- dhit asserted while IDLE is ignored.

Decomposition:
- Package cpu_types_pkg holds:
  - word_t (DW bits) and regbits_t (RW bits)
  - mem_state_t enum {IDLE, ACCESS}
  - a packed struct ex_mem_t grouping the latched fields, so the latch is a single register
- One sub-module is natural: mem_access_fsm. It owns the state, dREN/dWEN/stall generation and stall_cnt. The top module owns the ex_mem_t latch and mem_load_data.

Test Plan:
- Reset: hold RST for 2 cycles with ex_valid=1 → all outputs 0, stall_cnt=0, no dREN/dWEN.
- ALU pass-through: ex_rd=5, ex_regwr=1, ex_alu_out=0x1234, no memory op → next edge rd_mem=5, wr_mem=1, mem_alu_out=0x1234, stall never asserts. With ex_rd=0 → wr_mem=0.
- Load with 3-cycle miss: ex_memrd=1, addr 0x100, dhit low for 2 cycles then high with dload=0xDEADBEEF:
  - dREN=1 and daddr=0x100 for 3 cycles; stall=1 for 2 cycles.
  - mem_load_data=0xDEADBEEF after the hit edge; stall_cnt=2.
- Back-to-back store then load, each with a 1st-cycle hit:
  - Store (addr 0x200, data 0xA5A5A5A5) shows dWEN=1 and dstore=0xA5A5A5A5.
  - The next cycle shows dREN=1; FSM never visits IDLE; stall never asserts.
- Flush during stall: flush=1 raised while a load waits, held until the dhit edge → captured entry is a bubble (mem_valid=0, wr_mem=0), no new request.
- Halt, then reset mid-access:
  - ex_halt captured → mem_halt=1, latch frozen despite new ex_valid inputs.
  - RST asserted while in ACCESS → next cycle dREN=0, state IDLE, mem_halt=0.
